// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares framebuffer RAM port A between the host (p0) and the
// render engine (p1). It also contains a full back-buffer clear engine and
// front/back swap control that is synchronised to frame_end.
// Optional build macro FB_WRITE_STATS_EN adds saturating grant/drop counters.
module fb_write_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 24,
   parameter int MAX_ADDR = 2303
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              p0_valid,
   output logic              p0_ready,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_data,
   input  logic              p1_valid,
   output logic              p1_ready,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_data,
   input  logic              clr_start,
   input  logic [11:0]       clr_color,
   output logic              clr_busy,
   input  logic              swap_req,
   input  logic              frame_end,
   output logic              swap_pending,
   output logic              buf_sel,
   output logic              ram_we,
   output logic [ADDR_W:0]   ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              oob_err
`ifdef FB_WRITE_STATS_EN
   ,
   output logic [15:0]       stat_p0,
   output logic [15:0]       stat_p1,
   output logic [15:0]       stat_drop
`endif
);

   typedef enum logic {S_ARB, S_CLEAR} state_t;

   localparam logic [ADDR_W-1:0] LP_MAX = ADDR_W'(MAX_ADDR);

   state_t              r_state;
   logic                r_last;          // 1: p1 was granted last
   logic                r_buf_sel;
   logic                r_swap_pending;
   logic                r_we;
   logic                r_oob;
   logic [ADDR_W:0]     r_addr;
   logic [DATA_W-1:0]   r_data;

   logic                w_arb_ok;
   logic                w_clr_go;
   logic                w_g0;
   logic                w_g1;
   logic                w_oob;
   logic                w_swap;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]   w_data;

   // Grant decode, selected request and swap qualification
   always_comb begin
      w_clr_go = (r_state == S_ARB) && clr_start;
      w_arb_ok = (r_state == S_ARB) && !clr_start;
      w_g0     = w_arb_ok && p0_valid && (!p1_valid || r_last);
      w_g1     = w_arb_ok && p1_valid && (!p0_valid || !r_last);
      w_addr   = w_g1 ? p1_addr : p0_addr;
      w_data   = w_g1 ? p1_data : p0_data;
      w_oob    = (w_addr > LP_MAX);
      w_swap   = frame_end && (r_swap_pending || swap_req) && w_arb_ok;
   end

   // Arbiter/clear FSM with a registered RAM write stage.
   // During CLEAR the low address bits of r_addr act as the sweep counter.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= S_ARB;
         r_last  <= 1'b1;
         r_we    <= 1'b0;
         r_oob   <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         r_oob <= 1'b0;
         case (r_state)
            S_ARB: begin
               if (w_clr_go) begin
                  r_state <= S_CLEAR;
                  r_we    <= 1'b1;
                  r_addr  <= {~r_buf_sel, ADDR_W'(0)};
                  r_data  <= DATA_W'({clr_color, clr_color});
               end else if (w_g0 || w_g1) begin
                  r_last  <= w_g1;
                  r_we    <= ~w_oob;
                  r_oob   <= w_oob;
                  r_addr  <= {~r_buf_sel, w_addr};
                  r_data  <= w_data;
               end else begin
                  r_we    <= 1'b0;
               end
            end
            S_CLEAR: begin
               if (r_addr[ADDR_W-1:0] == LP_MAX) begin
                  r_state <= S_ARB;
                  r_we    <= 1'b0;
               end else begin
                  r_addr[ADDR_W-1:0] <= r_addr[ADDR_W-1:0] + 1'b1;
               end
            end
            default: begin
               r_state <= S_ARB;
               r_we    <= 1'b0;
            end
         endcase
      end
   end

   // Front/back buffer selection, swapped only at an allowed frame boundary
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_buf_sel      <= 1'b0;
         r_swap_pending <= 1'b0;
      end else if (w_swap) begin
         r_buf_sel      <= ~r_buf_sel;
         r_swap_pending <= 1'b0;
      end else if (swap_req) begin
         r_swap_pending <= 1'b1;
      end
   end

`ifdef FB_WRITE_STATS_EN
   logic        r_swap_d;
   logic [15:0] r_stat_p0;
   logic [15:0] r_stat_p1;
   logic [15:0] r_stat_drop;

   // Saturating grant/drop counters, cleared the cycle after a swap
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_swap_d    <= 1'b0;
         r_stat_p0   <= '0;
         r_stat_p1   <= '0;
         r_stat_drop <= '0;
      end else begin
         r_swap_d <= w_swap;
         if (r_swap_d) begin
            r_stat_p0   <= '0;
            r_stat_p1   <= '0;
            r_stat_drop <= '0;
         end else begin
            if (w_g0 && (r_stat_p0 != '1))
               r_stat_p0 <= r_stat_p0 + 16'd1;
            if (w_g1 && (r_stat_p1 != '1))
               r_stat_p1 <= r_stat_p1 + 16'd1;
            if ((w_g0 || w_g1) && w_oob && (r_stat_drop != '1))
               r_stat_drop <= r_stat_drop + 16'd1;
         end
      end
   end

   assign stat_p0   = r_stat_p0;
   assign stat_p1   = r_stat_p1;
   assign stat_drop = r_stat_drop;
`endif

   assign p0_ready     = w_g0;
   assign p1_ready     = w_g1;
   assign clr_busy     = (r_state == S_CLEAR);
   assign swap_pending = r_swap_pending;
   assign buf_sel      = r_buf_sel;
   assign ram_we       = r_we;
   assign ram_addr     = r_addr;
   assign ram_data     = r_data;
   assign oob_err      = r_oob;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: table-driven arbitration vectors and hand-written
// clear/swap/reset sequences, with a one-deep write scoreboard.
module tb_fb_write_arbiter;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        p0_valid, p1_valid;
   logic        p0_ready, p1_ready;
   logic [11:0] p0_addr, p1_addr;
   logic [23:0] p0_data, p1_data;
   logic        clr_start;
   logic [11:0] clr_color;
   logic        clr_busy;
   logic        swap_req, frame_end;
   logic        swap_pending, buf_sel;
   logic        ram_we;
   logic [12:0] ram_addr;
   logic [23:0] ram_data;
   logic        oob_err;
`ifdef FB_WRITE_STATS_EN
   logic [15:0] stat_p0, stat_p1, stat_drop;
`endif

   always #5 clk = ~clk;

   fb_write_arbiter #(.ADDR_W(12), .DATA_W(24), .MAX_ADDR(2303)) dut (
      .i_clk(clk), .i_rst(i_rst),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_data(p0_data),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_data(p1_data),
      .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
      .swap_req(swap_req), .frame_end(frame_end), .swap_pending(swap_pending),
      .buf_sel(buf_sel), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
      .oob_err(oob_err)
`ifdef FB_WRITE_STATS_EN
      , .stat_p0(stat_p0), .stat_p1(stat_p1), .stat_drop(stat_drop)
`endif
   );

   typedef struct packed {
      logic        we;
      logic        oob;
      logic [12:0] addr;
      logic [23:0] data;
   } wr_t;

   typedef struct {
      logic        p0v;
      logic [11:0] p0a;
      logic [23:0] p0d;
      logic        p1v;
      logic [11:0] p1a;
      logic [23:0] p1d;
      logic        e0;
      logic        e1;
   } vec_t;

   wr_t  q[$];
   vec_t tbl[12];
   int   n_cmp = 0;
   int   n_err = 0;
   logic m_buf = 1'b0;
   logic m_pend = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input logic [11:0] a, input logic [23:0] d);
      wr_t w;
      w.oob  = (a > 12'd2303);
      w.we   = ~w.oob;
      w.addr = {~m_buf, a};
      w.data = d;
      q.push_back(w);
   endtask

   // One ARB-mode cycle: compare last cycle's write, then this cycle's grants.
   task automatic step(input logic e0, input logic e1);
      wr_t w;
      @(negedge clk);
      if (q.size() != 0) begin
         w = q.pop_front();
         chk("ram_we", 64'(ram_we), 64'(w.we));
         chk("oob_err", 64'(oob_err), 64'(w.oob));
         if (w.we) begin
            chk("ram_addr", 64'(ram_addr), 64'(w.addr));
            chk("ram_data", 64'(ram_data), 64'(w.data));
         end
      end else begin
         chk("ram_we_idle", 64'(ram_we), 64'(0));
         chk("oob_err_idle", 64'(oob_err), 64'(0));
      end
      chk("clr_busy_arb", 64'(clr_busy), 64'(0));
      chk("p0_ready", 64'(p0_ready), 64'(e0));
      chk("p1_ready", 64'(p1_ready), 64'(e1));
      if (e0) push(p0_addr, p0_data);
      else if (e1) push(p1_addr, p1_data);
      if (frame_end && (m_pend || swap_req) && !clr_start) begin
         m_buf  = ~m_buf;
         m_pend = 1'b0;
      end else if (swap_req) begin
         m_pend = 1'b1;
      end
      @(posedge clk); #1;
      chk("buf_sel", 64'(buf_sel), 64'(m_buf));
      chk("swap_pending", 64'(swap_pending), 64'(m_pend));
   endtask

   // Full clear: the start cycle plus exactly 2304 busy cycles of writes.
   task automatic do_clear(input logic [11:0] col, input int fe_iter);
      int   bad_busy = 0, bad_rdy = 0, bad_we = 0, bad_addr = 0, bad_data = 0;
      logic msb;
      msb       = ~m_buf;
      clr_color = col;
      clr_start = 1'b1;
      step(1'b0, 1'b0);
      clr_start = 1'b0;
      clr_color = 12'h0AA;
      for (int i = 0; i < 2304; i++) begin
         @(negedge clk);
         if (clr_busy !== 1'b1) bad_busy++;
         if (p0_ready !== 1'b0 || p1_ready !== 1'b0) bad_rdy++;
         if (ram_we !== 1'b1) bad_we++;
         if (ram_addr !== {msb, 12'(i)}) bad_addr++;
         if (ram_data !== {col, col}) bad_data++;
         @(posedge clk); #1;
         frame_end = (i == fe_iter);
      end
      frame_end = 1'b0;
      chk("clear_busy_cycles", 64'(bad_busy), 64'(0));
      chk("clear_readies_low", 64'(bad_rdy), 64'(0));
      chk("clear_we", 64'(bad_we), 64'(0));
      chk("clear_addr", 64'(bad_addr), 64'(0));
      chk("clear_data", 64'(bad_data), 64'(0));
      chk("clear_buf_sel", 64'(buf_sel), 64'(m_buf));
   endtask

   task automatic idle_inputs();
      p0_valid = 1'b0; p1_valid = 1'b0;
      p0_addr = '0; p1_addr = '0; p0_data = '0; p1_data = '0;
   endtask

   initial begin
      i_rst = 1'b0;
      clr_start = 1'b0; clr_color = '0; swap_req = 1'b0; frame_end = 1'b0;
      idle_inputs();

      tbl[0]  = '{1'b1, 12'd5,    24'hABC123, 1'b0, 12'd0,    24'h0,      1'b1, 1'b0};
      tbl[1]  = '{1'b0, 12'd0,    24'h0,      1'b1, 12'd7,    24'h777777, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 12'd100,  24'hA00001, 1'b1, 12'd200,  24'hB00001, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 12'd101,  24'hA00002, 1'b1, 12'd200,  24'hB00001, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 12'd101,  24'hA00002, 1'b1, 12'd201,  24'hB00002, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 12'd102,  24'hA00003, 1'b1, 12'd201,  24'hB00002, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 12'd102,  24'hA00003, 1'b0, 12'd0,    24'h0,      1'b1, 1'b0};
      tbl[7]  = '{1'b0, 12'd0,    24'h0,      1'b1, 12'd2304, 24'hDEAD01, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 12'd2303, 24'h0F0F0F, 1'b0, 12'd0,    24'h0,      1'b1, 1'b0};
      tbl[9]  = '{1'b0, 12'd0,    24'h0,      1'b0, 12'd0,    24'h0,      1'b0, 1'b0};
      tbl[10] = '{1'b1, 12'hFFF,  24'h123456, 1'b0, 12'd0,    24'h0,      1'b1, 1'b0};
      tbl[11] = '{1'b0, 12'd0,    24'h0,      1'b0, 12'd0,    24'h0,      1'b0, 1'b0};

      // Reset state
      #12;
      chk("rst_ram_we", 64'(ram_we), 64'(0));
      chk("rst_ram_addr", 64'(ram_addr), 64'(0));
      chk("rst_ram_data", 64'(ram_data), 64'(0));
      chk("rst_oob", 64'(oob_err), 64'(0));
      chk("rst_busy", 64'(clr_busy), 64'(0));
      chk("rst_buf_sel", 64'(buf_sel), 64'(0));
      chk("rst_pending", 64'(swap_pending), 64'(0));
      @(posedge clk); #1;
      i_rst = 1'b1;

      // Arbitration / out-of-range vectors
      for (int i = 0; i < 12; i++) begin
         p0_valid = tbl[i].p0v; p0_addr = tbl[i].p0a; p0_data = tbl[i].p0d;
         p1_valid = tbl[i].p1v; p1_addr = tbl[i].p1a; p1_data = tbl[i].p1d;
         step(tbl[i].e0, tbl[i].e1);
      end

      // Clear wins over a waiting p0, then p0 is served once ARB resumes
      p0_valid = 1'b1; p0_addr = 12'd9; p0_data = 24'h123456;
      do_clear(12'hF00, -1);
      step(1'b1, 1'b0);
      idle_inputs();
      step(1'b0, 1'b0);

      // Swap at frame_end ten cycles after the request; repeated request is harmless
      swap_req = 1'b1;
      step(1'b0, 1'b0);
      swap_req = 1'b0;
      for (int i = 0; i < 9; i++) begin
         swap_req = (i == 4);
         step(1'b0, 1'b0);
      end
      swap_req = 1'b0;
      frame_end = 1'b1;
      step(1'b0, 1'b0);
      frame_end = 1'b0;
      chk("buf_sel_after_swap", 64'(buf_sel), 64'(1));
      p0_valid = 1'b1; p0_addr = 12'd3; p0_data = 24'h00BEEF;
      step(1'b1, 1'b0);
      idle_inputs();
      step(1'b0, 1'b0);

      // frame_end during a clear must not swap; the next one does
      swap_req = 1'b1;
      step(1'b0, 1'b0);
      swap_req = 1'b0;
      do_clear(12'h0F0, 100);
      chk("pending_after_clear", 64'(swap_pending), 64'(1));
      frame_end = 1'b1;
      step(1'b0, 1'b0);
      frame_end = 1'b0;
      chk("buf_sel_toggled_back", 64'(buf_sel), 64'(0));

      // Asynchronous reset during a write
      p0_valid = 1'b1; p0_addr = 12'h010; p0_data = 24'h55AA55;
      step(1'b1, 1'b0);
      idle_inputs();
      chk("we_before_rst", 64'(ram_we), 64'(1));
      #1 i_rst = 1'b0;
      #1;
      chk("we_async_rst", 64'(ram_we), 64'(0));
      q.delete();
      m_buf = 1'b0; m_pend = 1'b0;
      @(posedge clk); #1;
      i_rst = 1'b1;

      // Asynchronous reset during a clear
      swap_req = 1'b1;
      step(1'b0, 1'b0);
      swap_req = 1'b0;
      clr_start = 1'b1; clr_color = 12'h00F;
      step(1'b0, 1'b0);
      clr_start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("busy_mid_clear", 64'(clr_busy), 64'(1));
      i_rst = 1'b0;
      #1;
      chk("busy_after_rst", 64'(clr_busy), 64'(0));
      chk("we_after_rst", 64'(ram_we), 64'(0));
      chk("pending_after_rst", 64'(swap_pending), 64'(0));
      m_buf = 1'b0; m_pend = 1'b0;
      @(posedge clk); #1;
      i_rst = 1'b1;

      // Pointer is back at p1, so p0 wins the first tie after reset
      p0_valid = 1'b1; p0_addr = 12'd1; p0_data = 24'h000001;
      p1_valid = 1'b1; p1_addr = 12'd2; p1_data = 24'h000002;
      step(1'b1, 1'b0);
      p0_addr = 12'd4;
      step(1'b0, 1'b1);
      idle_inputs();
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
